// File: rtl/mem_stage_rx_if.sv
// rtl/mem_stage_rx_if.sv - EX->MEM->WB handshake and bus bundle for the MEM stage
//
// Purpose: groups the EX->MEM transfer, the data SRAM read return, and the
// MEM->WB / ID-forwarding outputs into one bundle.
// Modports:
//   slave  - the MEM stage view (consumes EX payload and rdata, drives WB bundle)
//   master - the surrounding pipeline / bench view
// Signals:
//   ms_allowin      MEM can accept from EX this cycle
//   es2ms_valid     EX presents a valid instruction
//   es_pc[31:0]     PC of the EX instruction
//   es_rf_zip[38:0] {res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0]}
//   data_sram_rdata read data, valid one cycle after the request
//   ws_allowin      WB can accept
//   ms2ws_valid     MEM presents a valid instruction to WB
//   ms_pc[31:0]     PC of the MEM instruction
//   ms_rf_zip[37:0] {rf_we, rf_waddr[4:0], rf_wdata[31:0]}
//   es_ld_op[2:0]   load width/sign code, only when MS_LD_EXT_EN is defined
interface mem_stage_rx_if;
  logic        ms_allowin;
  logic        es2ms_valid;
  logic [31:0] es_pc;
  logic [38:0] es_rf_zip;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ms2ws_valid;
  logic [31:0] ms_pc;
  logic [37:0] ms_rf_zip;
`ifdef MS_LD_EXT_EN
  logic [2:0]  es_ld_op;

  modport slave (
    input  es2ms_valid, es_pc, es_rf_zip, es_ld_op, data_sram_rdata, ws_allowin,
    output ms_allowin, ms2ws_valid, ms_pc, ms_rf_zip
  );
  modport master (
    output es2ms_valid, es_pc, es_rf_zip, es_ld_op, data_sram_rdata, ws_allowin,
    input  ms_allowin, ms2ws_valid, ms_pc, ms_rf_zip
  );
`else
  modport slave (
    input  es2ms_valid, es_pc, es_rf_zip, data_sram_rdata, ws_allowin,
    output ms_allowin, ms2ws_valid, ms_pc, ms_rf_zip
  );
  modport master (
    output es2ms_valid, es_pc, es_rf_zip, data_sram_rdata, ws_allowin,
    input  ms_allowin, ms2ws_valid, ms_pc, ms_rf_zip
  );
`endif
endinterface

// File: rtl/mem_stage_rx.sv
// rtl/mem_stage_rx.sv - MEM pipeline stage: EX handshake receiver and SRAM read return
//
// Purpose: latches the EX payload, picks up data_sram_rdata in the cycle after
// the request, keeps that word if WB back-pressures, and presents the writeback
// bundle to WB (also used by ID for forwarding).
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   bus    mem_stage_rx_if.slave (EX payload in, rdata in, ws_allowin in,
//          ms_allowin / ms2ws_valid / ms_pc / ms_rf_zip out)
// Optional feature: MS_LD_EXT_EN adds es_ld_op and byte/halfword load
// extraction with sign/zero extension; without it every load returns the word.
module mem_stage_rx (
  input  logic clk,
  input  logic reset,
  mem_stage_rx_if.slave bus
);

  logic        ms_valid;
  logic        first_cycle;
  logic        hold_vld;
  logic [31:0] hold_data;
  logic [31:0] pc_r;
  logic        res_from_mem;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] alu_result;
  logic        allowin;
  logic        accept;
  logic [31:0] mem_word;
  logic [31:0] load_val;
  logic [31:0] rf_wdata;

  // Ready-go is always 1, so the entry leaves whenever WB accepts.
  assign allowin = ~ms_valid | bus.ws_allowin;
  assign accept  = bus.es2ms_valid & allowin;

`ifdef MS_LD_EXT_EN
  logic [2:0] ld_op;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid     <= 1'b0;
      first_cycle  <= 1'b0;
      hold_vld     <= 1'b0;
      hold_data    <= 32'd0;
      pc_r         <= 32'd0;
      res_from_mem <= 1'b0;
      rf_we        <= 1'b0;
      rf_waddr     <= 5'd0;
      alu_result   <= 32'd0;
`ifdef MS_LD_EXT_EN
      ld_op        <= 3'd0;
`endif
    end else begin
      if (allowin) begin
        ms_valid <= bus.es2ms_valid;
      end
      if (accept) begin
        pc_r                                          <= bus.es_pc;
        {res_from_mem, rf_we, rf_waddr, alu_result}   <= bus.es_rf_zip;
        first_cycle                                   <= 1'b1;
        hold_vld                                      <= 1'b0;
`ifdef MS_LD_EXT_EN
        ld_op                                         <= bus.es_ld_op;
`endif
      end else begin
        first_cycle <= 1'b0;
        // rdata is only valid in the first MEM cycle; keep it if WB stalls us.
        if (ms_valid & first_cycle & res_from_mem & ~bus.ws_allowin) begin
          hold_data <= bus.data_sram_rdata;
          hold_vld  <= 1'b1;
        end else if (bus.ws_allowin) begin
          hold_vld  <= 1'b0;
        end
      end
    end
  end

  assign mem_word = hold_vld ? hold_data : bus.data_sram_rdata;

`ifdef MS_LD_EXT_EN
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = mem_word[7:0];
    case (alu_result[1:0])
      2'd0:    ld_byte = mem_word[7:0];
      2'd1:    ld_byte = mem_word[15:8];
      2'd2:    ld_byte = mem_word[23:16];
      default: ld_byte = mem_word[31:24];
    endcase
    ld_half = alu_result[1] ? mem_word[31:16] : mem_word[15:0];
    case (ld_op)
      3'b001:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b011:  load_val = {24'd0, ld_byte};
      3'b100:  load_val = {16'd0, ld_half};
      default: load_val = mem_word;
    endcase
  end
`else
  assign load_val = mem_word;
`endif

  assign rf_wdata = res_from_mem ? load_val : alu_result;

  assign bus.ms_allowin  = allowin;
  assign bus.ms2ws_valid = ms_valid;
  assign bus.ms_pc       = pc_r;
  assign bus.ms_rf_zip   = {rf_we & ms_valid, rf_waddr, rf_wdata};

endmodule
